// File: rtl/nios_q_out.sv
// Avalon-MM output PIO with set/clear writes and a cycle-exact pulse timer
// that inverts masked output bits for a programmed number of clocks.
module nios_q_out #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              PULSE_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [PULSE_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               we;
    logic [WIDTH-1:0]   wd;
    logic [PULSE_W-1:0] wl;
    logic               unused_wd;

    assign we        = chipselect && !write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign wl        = writedata[PULSE_W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d  = data_q;
        mask_d  = mask_q;
        state_d = state_q;
        count_d = count_q;
        if (state_q == ACTIVE) begin
            count_d = count_q - PULSE_W'(1);
            if (count_q == PULSE_W'(1))
                state_d = IDLE;
        end
        if (we) begin
            case (address)
                3'd0: data_d = wd;
                3'd1: mask_d = wd;
                3'd2: begin
                    count_d = wl;
                    state_d = (wl != '0) ? ACTIVE : IDLE;
                end
                3'd4: data_d = data_q | wd;
                3'd5: data_d = data_q & ~wd;
                default: ;
            endcase
        end
        // Old mask on purpose: a mask write reaches the pins one cycle later.
        out_d = data_d ^ ((state_d == ACTIVE) ? mask_q : '0);
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            3'd0: rdata_d = 32'(data_q);
            3'd1: rdata_d = 32'(mask_q);
            3'd2: rdata_d = 32'(count_q);
            3'd3: rdata_d = {31'b0, state_q == ACTIVE};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            out_q   <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rdata_q;
endmodule
